// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package prog_loader_pkg;
   localparam int INSTR_W = 8;
   localparam logic [3:0] HDR_MAGIC = 4'hA;

   typedef logic [INSTR_W-1:0] instruction_t;

   typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, RELEASE, RUN, ERR} loader_state_t;
   typedef enum logic [1:0] {ERR_NONE, ERR_HDR, ERR_CSUM, ERR_TIMEOUT} loader_err_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface prog_loader_if #(
   parameter int ADDR_WIDTH = 4
);
   import prog_loader_pkg::*;

   logic                  in_valid;
   instruction_t          in_data;
   logic                  in_ready;
   logic                  prog_enable;
   logic                  prog_we;
   logic [ADDR_WIDTH-1:0] prog_addr;
   instruction_t          prog_data;

   modport master (input in_valid, in_data,
                   output in_ready, prog_enable, prog_we, prog_addr, prog_data);
   modport slave  (output in_valid, in_data,
                   input in_ready, prog_enable, prog_we, prog_addr, prog_data);
endinterface

// File: rtl/prog_loader.sv
// Loads a framed program (header, N instructions, XOR checksum) into instruction
// memory while holding the CPU in reset; releases it after a settle delay.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_WIDTH     = 4,
   parameter int INSTR_WIDTH    = INSTR_W,
   parameter int RELEASE_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load_req,
   prog_loader_if.master       bus,
   output logic                cpu_reset,
   output logic                done,
   output logic                err,
   output logic [1:0]          err_code
);
   localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(RELEASE_CYCLES + 1);

   loader_state_t          state, nxt;
   loader_err_t            code_q, code_nxt;
   logic [3:0]             cnt;
   logic [ADDR_WIDTH-1:0]  idx;
   logic [RW-1:0]          rel_cnt;
   logic [GW-1:0]          gap;
   logic [INSTR_WIDTH-1:0] csum;
   logic                   in_ready, prog_enable, prog_we;
   logic [ADDR_WIDTH-1:0]  prog_addr;
   instruction_t           prog_data;
   logic                   busy, accept, timeout;

   assign busy    = (state == HDR) || (state == DATA) || (state == CSUM);
   assign accept  = bus.in_valid && in_ready;
   assign timeout = busy && !accept && (gap == GW'(TIMEOUT_CYCLES - 1));

   assign bus.in_ready    = in_ready;
   assign bus.prog_enable = prog_enable;
   assign bus.prog_we     = prog_we;
   assign bus.prog_addr   = prog_addr;
   assign bus.prog_data   = prog_data;
   assign err_code        = code_q;

   always_comb begin
      nxt      = state;
      code_nxt = code_q;
      unique case (state)
         IDLE: if (load_req) nxt = HDR;
         HDR: begin
            if (timeout) begin
               nxt = ERR; code_nxt = ERR_TIMEOUT;
            end else if (accept) begin
               if (bus.in_data[7:4] == HDR_MAGIC) nxt = DATA;
               else begin
                  nxt = ERR; code_nxt = ERR_HDR;
               end
            end
         end
         DATA: begin
            if (timeout) begin
               nxt = ERR; code_nxt = ERR_TIMEOUT;
            end else if (accept && idx == ADDR_WIDTH'(cnt)) nxt = CSUM;
         end
         CSUM: begin
            if (timeout) begin
               nxt = ERR; code_nxt = ERR_TIMEOUT;
            end else if (accept) begin
               if (bus.in_data == csum) nxt = RELEASE;
               else begin
                  nxt = ERR; code_nxt = ERR_CSUM;
               end
            end
         end
         RELEASE: if (rel_cnt == RW'(RELEASE_CYCLES - 1)) nxt = RUN;
         RUN, ERR: if (load_req) begin
            nxt = HDR; code_nxt = ERR_NONE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         code_q      <= ERR_NONE;
         cnt         <= '0;
         idx         <= '0;
         rel_cnt     <= '0;
         in_ready    <= 1'b0;
         prog_enable <= 1'b0;
         prog_we     <= 1'b0;
         prog_addr   <= '0;
         prog_data   <= '0;
         cpu_reset   <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= nxt;
         code_q      <= code_nxt;
         in_ready    <= (nxt == HDR) || (nxt == DATA) || (nxt == CSUM);
         prog_enable <= (nxt == HDR) || (nxt == DATA) || (nxt == CSUM);
         cpu_reset   <= (nxt != RUN);
         done        <= (nxt == RUN);
         err         <= (nxt == ERR);
         prog_we     <= (state == DATA) && accept;
         rel_cnt     <= (state == RELEASE) ? rel_cnt + 1'b1 : '0;
         if (state == HDR && accept) begin
            cnt <= bus.in_data[3:0];
            idx <= '0;
         end
         if (state == DATA && accept) begin
            prog_data <= bus.in_data;
            prog_addr <= idx;
            idx       <= idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)          gap <= '0;
      else if (busy && !accept) gap <= gap + 1'b1;
      else                   gap <= '0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n)                   csum <= '0;
      else if (state == HDR && accept)  csum <= '0;
      else if (state == DATA && accept) csum <= csum ^ bus.in_data;
   end
endmodule

// File: tb/tb_prog_loader.sv
// Directed-vector bench for prog_loader: framing, write strobes, errors, timeout, reset.
module tb_prog_loader;
   logic       clk = 1'b0;
   logic       reset_n, load_req;
   logic       cpu_reset, done, err;
   logic [1:0] err_code;
   int         errors = 0, checks = 0, cyc = 0;
   logic [3:0] wa[$];
   logic [7:0] wd[$];
   int         wc[$];
   logic [7:0] mem [16];

   prog_loader_if #(.ADDR_WIDTH(4)) bus();

   prog_loader #(.ADDR_WIDTH(4), .INSTR_WIDTH(8), .RELEASE_CYCLES(2), .TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .reset_n(reset_n), .load_req(load_req), .bus(bus),
      .cpu_reset(cpu_reset), .done(done), .err(err), .err_code(err_code));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (bus.prog_we) begin
         wa.push_back(bus.prog_addr);
         wd.push_back(bus.prog_data);
         wc.push_back(cyc);
         mem[bus.prog_addr] <= bus.prog_data;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_load();
      load_req = 1'b1; tick(); load_req = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic ok = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = b;
      for (int n = 0; n < 20 && !ok; n++) begin
         ok = bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++; $display("FAIL send_byte %h: not accepted within 20 cycles", b);
      end
   endtask

   task automatic wait_run(input string name);
      int n = 0;
      while (!done && n < 20) begin tick(); n++; end
      checks++;
      if (done !== 1'b1 || cpu_reset !== 1'b0) begin
         errors++; $display("FAIL %s: done=%b cpu_reset=%b, want 1/0", name, done, cpu_reset);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; load_req = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00;
      tick(); tick(); load_req = 1'b0; tick();
      checks++;
      if ({cpu_reset, bus.prog_enable, bus.prog_we, bus.in_ready, done, err, err_code,
           bus.prog_addr, bus.prog_data} !== 20'h80000) begin
         errors++; $display("FAIL reset_state: cpu_reset=%b pe=%b we=%b rdy=%b done=%b err=%b code=%0d addr=%0d data=%h",
            cpu_reset, bus.prog_enable, bus.prog_we, bus.in_ready, done, err, err_code, bus.prog_addr, bus.prog_data);
      end
      reset_n = 1'b1; tick();
   endtask

   task automatic test_basic_load();
      wa.delete(); wd.delete(); wc.delete();
      pulse_load();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.prog_enable !== 1'b1 || cpu_reset !== 1'b1) begin
         errors++; $display("FAIL hdr_entry: rdy=%b pe=%b cpu_reset=%b, want 1/1/1", bus.in_ready, bus.prog_enable, cpu_reset);
      end
      send_byte(8'hA2); send_byte(8'h13); send_byte(8'h27); send_byte(8'h41); send_byte(8'h75);
      checks++;
      if (wa.size() != 3 || wa[0] !== 4'd0 || wa[1] !== 4'd1 || wa[2] !== 4'd2 ||
          wd[0] !== 8'h13 || wd[1] !== 8'h27 || wd[2] !== 8'h41) begin
         errors++; $display("FAIL basic_writes: count=%0d, want 3 writes 0:13 1:27 2:41", wa.size());
      end
      checks++;
      if (wc.size() != 3 || wc[1] != wc[0] + 1 || wc[2] != wc[1] + 1) begin
         errors++; $display("FAIL basic_b2b: write cycles not consecutive (count=%0d)", wc.size());
      end
      checks++;
      if (bus.prog_enable !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL release_entry: pe=%b cpu_reset=%b done=%b, want 0/1/0", bus.prog_enable, cpu_reset, done);
      end
      tick();
      checks++;
      if (cpu_reset !== 1'b1) begin
         errors++; $display("FAIL release_hold: cpu_reset=%b, want 1", cpu_reset);
      end
      tick();
      checks++;
      if (cpu_reset !== 1'b0 || done !== 1'b1 || mem[1] !== 8'h27) begin
         errors++; $display("FAIL run_entry: cpu_reset=%b done=%b mem1=%h, want 0/1/27", cpu_reset, done, mem[1]);
      end
   endtask

   task automatic test_run_reload();
      pulse_load();
      checks++;
      if (cpu_reset !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL run_reload: cpu_reset=%b done=%b rdy=%b, want 1/0/1", cpu_reset, done, bus.in_ready);
      end
   endtask

   task automatic test_bad_header();
      int n0 = wa.size();
      send_byte(8'h5F); tick();
      checks++;
      if (err !== 1'b1 || err_code !== 2'd1 || cpu_reset !== 1'b1 || wa.size() != n0) begin
         errors++; $display("FAIL bad_header: err=%b code=%0d cpu_reset=%b writes=%0d, want 1/1/1/0",
            err, err_code, cpu_reset, wa.size() - n0);
      end
   endtask

   task automatic test_csum_err();
      pulse_load();
      checks++;
      if (err !== 1'b0 || err_code !== 2'd0) begin
         errors++; $display("FAIL err_clear: err=%b code=%0d, want 0/0", err, err_code);
      end
      wa.delete(); wd.delete(); wc.delete();
      send_byte(8'hA0); send_byte(8'h3C); send_byte(8'h3D);
      checks++;
      if (err !== 1'b1 || err_code !== 2'd2 || done !== 1'b0 || wa.size() != 1 ||
          wa[0] !== 4'd0 || wd[0] !== 8'h3C) begin
         errors++; $display("FAIL csum_err: err=%b code=%0d done=%b writes=%0d, want 1/2/0/1 (0:3C)",
            err, err_code, done, wa.size());
      end
   endtask

   task automatic test_full_frame();
      logic bad = 1'b0;
      pulse_load();
      wa.delete(); wd.delete(); wc.delete();
      send_byte(8'hAF);
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i)); tick();
      end
      send_byte(8'h00);
      for (int i = 0; i < 16; i++)
         if (wa.size() != 16 || wa[i] !== 4'(i) || wd[i] !== 8'(i)) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++; $display("FAIL full_writes: count=%0d, want 16 writes i:i", wa.size());
      end
      wait_run("full_run");
   endtask

   task automatic test_timeout();
      pulse_load();
      send_byte(8'hA3); send_byte(8'h11); send_byte(8'h22);
      repeat (254) tick();
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL timeout_early: err=%b after 254 idle cycles, want 0", err);
      end
      tick();
      checks++;
      if (err !== 1'b1 || err_code !== 2'd3 || cpu_reset !== 1'b1) begin
         errors++; $display("FAIL timeout: err=%b code=%0d cpu_reset=%b, want 1/3/1", err, err_code, cpu_reset);
      end
      pulse_load();
      send_byte(8'hA1); send_byte(8'h5A); send_byte(8'h0F); send_byte(8'h55);
      wait_run("timeout_recover");
   endtask

   task automatic test_reset_mid_data();
      pulse_load();
      send_byte(8'hA3); send_byte(8'h01); send_byte(8'h02);
      reset_n = 1'b0; tick();
      checks++;
      if ({cpu_reset, bus.prog_enable, bus.prog_we, bus.in_ready, done, err, err_code,
           bus.prog_addr, bus.prog_data} !== 20'h80000) begin
         errors++; $display("FAIL reset_mid_data: cpu_reset=%b pe=%b we=%b rdy=%b addr=%0d data=%h",
            cpu_reset, bus.prog_enable, bus.prog_we, bus.in_ready, bus.prog_addr, bus.prog_data);
      end
      reset_n = 1'b1; tick();
      checks++;
      if (bus.in_ready !== 1'b0 || cpu_reset !== 1'b1) begin
         errors++; $display("FAIL idle_after_reset: rdy=%b cpu_reset=%b, want 0/1", bus.in_ready, cpu_reset);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_run_reload();
      test_bad_header();
      test_csum_err();
      test_full_frame();
      test_timeout();
      test_reset_mid_data();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
